// File: rtl/regfile_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sequencer_if
// Description : Register-file port between regfile_sequencer (master) and
//               processor (slave). The master drives register addresses,
//               write data and the operation. The slave returns the two
//               read ports.
//   rs1, rs2          5         register addresses (master -> slave)
//   rd_in             WORDSIZE  write data       (master -> slave)
//   op_code           7         operation, 0=NOP (master -> slave)
//   rs1_out, rs2_out  WORDSIZE  read data        (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_sequencer_if #(
    parameter int WORDSIZE = 64
);
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [WORDSIZE-1:0] rd_in;
    logic [6:0]          op_code;
    logic [WORDSIZE-1:0] rs1_out;
    logic [WORDSIZE-1:0] rs2_out;

    modport master (
        output rs1, rs2, rd_in, op_code,
        input  rs1_out, rs2_out
    );

    modport slave (
        input  rs1, rs2, rd_in, op_code,
        output rs1_out, rs2_out
    );
endinterface
`default_nettype wire

// File: rtl/regfile_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sequencer
// Description : Programmable initiator for the processor register-file port.
//               A program memory is written word by word while idle. A start
//               pulse runs it: each instruction is fetched, issued for one
//               cycle, waited on for RD_LATENCY cycles, and then its read data
//               is captured and added to a running checksum.
//   clk, reset          clock, asynchronous active-high reset
//   prog_we/addr/data   program write port (ignored while busy)
//   start               run request (sampled only when idle)
//   bus                 register-file port (master side)
//   busy, done          run status; done is a one-cycle pulse
//   result_a/b          last captured rs1_out/rs2_out
//   checksum            wrapping sum of all captured rs1_out + rs2_out
//   instr_count         instructions issued in the current/last run
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_sequencer #(
    parameter int WORDSIZE   = 64,
    parameter int PROG_DEPTH = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          prog_we,
    input  logic [$clog2(PROG_DEPTH)-1:0] prog_addr,
    input  logic [32:0]                   prog_data,
    input  logic                          start,
    regfile_sequencer_if.master           bus,
    output logic                          busy,
    output logic                          done,
    output logic [WORDSIZE-1:0]           result_a,
    output logic [WORDSIZE-1:0]           result_b,
    output logic [WORDSIZE-1:0]           checksum,
    output logic [$clog2(PROG_DEPTH):0]   instr_count
);

    localparam int AW = $clog2(PROG_DEPTH);
    localparam int LW = $clog2(RD_LATENCY + 2);
    localparam logic [LW-1:0] WAIT_LOAD = (RD_LATENCY > 0) ? LW'(RD_LATENCY - 1) : '0;
    localparam logic [AW-1:0] LAST_PC   = AW'(PROG_DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_ISSUE   = 3'd2,
        S_WAIT    = 3'd3,
        S_CAPTURE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t              state;
    logic [AW-1:0]       pc;
    logic [LW-1:0]       wait_cnt;
    logic [6:0]          op_code_q;
    logic [4:0]          rs1_q;
    logic [4:0]          rs2_q;
    logic [WORDSIZE-1:0] rd_in_q;

    // Program memory has no reset so its contents survive resets and runs.
    logic [32:0] mem [PROG_DEPTH];
    logic [32:0] fetch_word;

    assign fetch_word = mem[pc];

    // Writes only land while idle, including the cycle start is accepted,
    // so a word written alongside start is already in place for FETCH.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && prog_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    assign bus.op_code = op_code_q;
    assign bus.rs1     = rs1_q;
    assign bus.rs2     = rs2_q;
    assign bus.rd_in   = rd_in_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            pc          <= '0;
            wait_cnt    <= '0;
            op_code_q   <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_in_q     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result_a    <= '0;
            result_b    <= '0;
            checksum    <= '0;
            instr_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pc          <= '0;
                        checksum    <= '0;
                        instr_count <= '0;
                        busy        <= 1'b1;
                        state       <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    // The issue registers are loaded here so the operation
                    // appears on the bus for exactly the ISSUE cycle.
                    if (fetch_word[32:26] == 7'd0) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        op_code_q <= fetch_word[32:26];
                        rs1_q     <= fetch_word[25:21];
                        rs2_q     <= fetch_word[20:16];
                        rd_in_q   <= {{(WORDSIZE-16){fetch_word[15]}}, fetch_word[15:0]};
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    op_code_q   <= '0;
                    instr_count <= instr_count + (AW+1)'(1);
                    if (RD_LATENCY == 0) begin
                        state <= S_CAPTURE;
                    end else begin
                        wait_cnt <= WAIT_LOAD;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= S_CAPTURE;
                    end else begin
                        wait_cnt <= wait_cnt - LW'(1);
                    end
                end
                S_CAPTURE: begin
                    result_a <= bus.rs1_out;
                    result_b <= bus.rs2_out;
                    checksum <= checksum + bus.rs1_out + bus.rs2_out;
                    if (pc == LAST_PC) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        pc    <= pc + AW'(1);
                        state <= S_FETCH;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_sequencer
// Description : Self-checking bench for regfile_sequencer. A behavioural
//               processor model answers the register-file port. A reference
//               model walks the program array to predict the issues and the
//               end-of-run results. A monitor compares them as the DUT
//               presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_sequencer;

    localparam int WS    = 64;
    localparam int DEPTH = 16;
    localparam int LAT   = 1;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [32:0]   prog_data = '0;
    logic          start = 1'b0;
    logic          busy, done;
    logic [WS-1:0] result_a, result_b, checksum;
    logic [AW:0]   instr_count;

    regfile_sequencer_if #(.WORDSIZE(WS)) bus ();

    regfile_sequencer #(.WORDSIZE(WS), .PROG_DEPTH(DEPTH), .RD_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .start(start), .bus(bus), .busy(busy), .done(done),
        .result_a(result_a), .result_b(result_b), .checksum(checksum),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] init_val(int i);
        case (i)
            1:       return 64'd1;
            2:       return 64'd2;
            3:       return 64'hFFFF_FFFF_FFFF_FFFF;
            5:       return 64'd1;
            default: return {32'(i), 32'hA5A5_0000 + 32'(i)};
        endcase
    endfunction

    function automatic logic [63:0] sext(logic [15:0] imm);
        return {{48{imm[15]}}, imm};
    endfunction

    function automatic logic [32:0] ins(int op, int r1, int r2, int imm);
        return {7'(op), 5'(r1), 5'(r2), 16'(imm)};
    endfunction

    // Processor model: op 1 writes rs1 <- rd_in; read ports are registered.
    bit          pm_init;
    logic [63:0] pm_regs [32];
    always @(posedge clk) begin
        if (!pm_init) begin
            for (int i = 0; i < 32; i++) pm_regs[i] <= init_val(i);
            pm_init <= 1'b1;
        end else if (bus.op_code == 7'd1) begin
            pm_regs[bus.rs1] <= bus.rd_in;
        end
        bus.rs1_out <= pm_regs[bus.rs1];
        bus.rs2_out <= pm_regs[bus.rs2];
    end

    // Reference state
    logic [32:0] prog [DEPTH];
    logic [63:0] ref_regs [32];
    logic [63:0] ref_ra = '0, ref_rb = '0;

    typedef struct { logic [6:0] op; logic [4:0] rs1; logic [4:0] rs2; logic [63:0] rd; } iss_t;
    typedef struct { longint cyc; logic [63:0] cs; logic [63:0] ra; logic [63:0] rb; logic [AW:0] ic; } run_t;
    iss_t iss_q[$];
    run_t run_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Walk the program as the sequencer should execute it and queue the
    // expected issues and the end-of-run summary.
    task automatic predict(longint c);
        int          n = 0;
        bit          halted = 1'b0;
        logic [63:0] cs = '0;
        logic [32:0] w;
        for (int p = 0; p < DEPTH; p++) begin
            w = prog[p];
            if (w[32:26] == 7'd0) begin
                halted = 1'b1;
                break;
            end
            iss_q.push_back('{w[32:26], w[25:21], w[20:16], sext(w[15:0])});
            if (w[32:26] == 7'd1) ref_regs[w[25:21]] = sext(w[15:0]);
            ref_ra = ref_regs[w[25:21]];
            ref_rb = ref_regs[w[20:16]];
            cs = cs + ref_ra + ref_rb;
            n++;
        end
        run_q.push_back('{c + (halted ? 2 : 1) + longint'(n * (3 + LAT)), cs, ref_ra, ref_rb, (AW+1)'(n)});
    endtask

    // Monitor: pops expectations whenever the DUT issues or signals done.
    initial begin
        bit   prev_issue = 1'b0;
        iss_t e;
        run_t r;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus.op_code != 7'd0) begin
                    chk("op_code one cycle", 128'(prev_issue), 128'd0);
                    if (iss_q.size() == 0) begin
                        chk("unexpected issue", 128'(bus.op_code), 128'd0);
                    end else begin
                        e = iss_q.pop_front();
                        chk("issue", {bus.op_code, bus.rs1, bus.rs2, bus.rd_in},
                            {e.op, e.rs1, e.rs2, e.rd});
                    end
                    prev_issue = 1'b1;
                end else begin
                    prev_issue = 1'b0;
                end
                if (done) begin
                    if (run_q.size() == 0) begin
                        chk("unexpected done", 128'(done), 128'd0);
                    end else begin
                        r = run_q.pop_front();
                        chk("done cycle", 128'(cyc), 128'(r.cyc));
                        chk("checksum", 128'(checksum), 128'(r.cs));
                        chk("instr_count", 128'(instr_count), 128'(r.ic));
                        chk("result_a", 128'(result_a), 128'(r.ra));
                        chk("result_b", 128'(result_b), 128'(r.rb));
                    end
                end
            end else begin
                prev_issue = 1'b0;
            end
        end
    end

    task automatic wr(int a, logic [32:0] d);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = AW'(a); prog_data = d; prog[a] = d;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400 && run_q.size() != 0; i++) @(negedge clk);
        if (run_q.size() != 0) begin
            chk("run timeout", 128'(run_q.size()), 128'd0);
            run_q.delete();
        end
        chk("issues drained", 128'(iss_q.size()), 128'd0);
        iss_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic run_prog(input bit with_wr = 1'b0, input int wa = 0, input logic [32:0] wd = '0);
        @(negedge clk);
        if (with_wr) begin
            prog_we = 1'b1; prog_addr = AW'(wa); prog_data = wd; prog[wa] = wd;
        end
        predict(cyc);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; prog_we = 1'b0;
        wait_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        longint c0;
        int     h;
        int     op;
        for (int i = 0; i < 32; i++) ref_regs[i] = init_val(i);
        for (int i = 0; i < DEPTH; i++) prog[i] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset bus", {bus.op_code, bus.rs1, bus.rs2, bus.rd_in}, 128'd0);
        chk("reset busy/done", {busy, done}, 128'd0);
        chk("reset results", {result_a, result_b}, 128'd0);
        chk("reset checksum", 128'(checksum), 128'd0);
        chk("reset instr_count", 128'(instr_count), 128'd0);
        reset = 1'b0;

        // Write reg 4 then read it back
        wr(0, ins(1, 4, 0, 16'hE01A));
        wr(1, ins(2, 4, 0, 0));
        wr(2, '0);
        run_prog();
        chk("wr/rd result_a", 128'(result_a), 128'h FFFF_FFFF_FFFF_E01A);
        chk("wr/rd instr_count", 128'(instr_count), 128'd2);

        // Halt at address 0
        wr(0, '0);
        run_prog();
        chk("halt instr_count", 128'(instr_count), 128'd0);

        // Full program, no halt
        for (int p = 0; p < DEPTH; p++) wr(p, ins(2, 1, 2, p));
        run_prog();
        chk("full checksum", 128'(checksum), 128'd48);
        chk("full instr_count", 128'(instr_count), 128'd16);

        // Checksum wrap
        wr(0, ins(3, 3, 5, 0));
        wr(1, ins(3, 3, 5, 1));
        wr(2, '0);
        run_prog();
        chk("wrap checksum", 128'(checksum), 128'd0);

        // Busy protection: write and second start mid-run are ignored
        for (int p = 0; p < 4; p++) wr(p, ins(2, 6 + p, 7 + p, p));
        wr(4, '0);
        @(negedge clk);
        predict(cyc);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy mid-run", 128'(busy), 128'd1);
        prog_we = 1'b1; prog_addr = 4'd1; prog_data = ins(1, 9, 0, 16'h1234); start = 1'b1;
        @(negedge clk);
        prog_we = 1'b0; start = 1'b0;
        wait_idle();
        run_prog();

        // Reset mid-run during WAIT of the second instruction
        @(negedge clk);
        predict(cyc);
        c0 = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("pre-reset cycle", 128'(cyc - c0), 128'd7);
        chk("pre-reset busy", 128'(busy), 128'd1);
        reset = 1'b1;
        #1;
        chk("mid-reset op_code", 128'(bus.op_code), 128'd0);
        chk("mid-reset busy/done", {busy, done}, 128'd0);
        chk("mid-reset checksum", 128'(checksum), 128'd0);
        iss_q.delete();
        run_q.delete();
        ref_ra = '0; ref_rb = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("post-reset results", {result_a, result_b}, 128'd0);
        run_prog();

        // Randomized programs; the final word is written together with start
        for (int t = 0; t < 6; t++) begin
            h = $urandom_range(0, DEPTH);
            for (int p = 0; p < DEPTH - 1 && p < h; p++) begin
                op = ($urandom_range(0, 3) == 0) ? 1 : int'($urandom_range(2, 127));
                wr(p, ins(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 65535)));
            end
            if (h < DEPTH) run_prog(1'b1, h, '0);
            else run_prog(1'b1, DEPTH - 1, ins(int'($urandom_range(1, 127)), $urandom_range(0, 31),
                                              $urandom_range(0, 31), $urandom_range(0, 65535)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_sequencer.md
# regfile_sequencer

Programmable initiator that drives the register-file port of `processor` (`rs1`, `rs2`, `rd_in`, `op_code`) and captures its read data (`rs1_out`, `rs2_out`). It replaces hand-sequenced stimulus. A small internal program memory is loaded word by word, and a `start` pulse runs it. Each captured result is exposed and folded into a running checksum for self-checking.

## Interface
- `WORDSIZE`, 64, data width; matches `processor`.
- `PROG_DEPTH`, 16, number of program words (power of two, ≥2).
- `RD_LATENCY`, 1, cycles between issue and capture of `rs1_out`/`rs2_out` (≥0).
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `prog_we`  in  1  program write strobe; ignored while `busy`.
- `prog_addr`  in  log2(PROG_DEPTH)  program write address.
- `prog_data`  in  33  instruction {op[32:26], rs1[25:21], rs2[20:16], imm[15:0]}.
- `start`  in  1  run request; sampled only in IDLE.
- `rs1_out`, `rs2_out`  in  WORDSIZE  read data from `processor`.
- `rs1`, `rs2`  out  5  register addresses to `processor`.
- `rd_in`  out  WORDSIZE  write data to `processor`, imm sign-extended.
- `op_code`  out  7  operation to `processor`; 0 = NOP.
- `busy`  out  1  high from the cycle after `start` until DONE is left.
- `done`  out  1  one-cycle pulse at end of run.
- `result_a`, `result_b`  out  WORDSIZE  last captured `rs1_out`/`rs2_out`.
- `checksum`  out  WORDSIZE  wrapping sum of all captured `rs1_out + rs2_out`.
- `instr_count`  out  log2(PROG_DEPTH)+1  instructions issued in current/last run.

## Operation
- FSM states: IDLE, FETCH, ISSUE, WAIT, CAPTURE, DONE.
- IDLE:
  - `prog_we`=1 writes `prog_data` to `mem[prog_addr]`.
  - `start`=1 clears `pc`, `checksum`, and `instr_count`, then goes to FETCH.
  - `prog_we` and `start` asserted in the same cycle: the write is performed and the run starts; the written word is visible to FETCH.
- FETCH: latches `mem[pc]` into the instruction register.
  - Instruction op = 0 (halt): go to DONE; nothing is issued.
  - Otherwise: go to ISSUE.
- ISSUE: for exactly one cycle, drive `op_code`=op, `rs1`, `rs2`, and `rd_in`={{(WORDSIZE-16){imm[15]}},imm}. Increment `instr_count`. Go to WAIT, or to CAPTURE if RD_LATENCY=0.
- WAIT: `op_code`=0. `rs1`, `rs2`, and `rd_in` hold their values. Stay RD_LATENCY cycles (down-counter), then go to CAPTURE.
- CAPTURE:
  - Register `result_a`←`rs1_out` and `result_b`←`rs2_out`.
  - `checksum`←`checksum + rs1_out + rs2_out`, modulo 2^WORDSIZE.
  - If `pc`=PROG_DEPTH-1, go to DONE (no wrap-around execution). Otherwise `pc`←`pc+1` and go to FETCH.
- DONE: `done`=1 for one cycle, `busy`=0, go to IDLE. Results and counts hold until the next `start`.
- `start` or `prog_we` while `busy`: ignored.
- Program memory is not cleared by reset; contents persist across runs and resets.

## Timing
- Reset (async, immediate) values:
  - `op_code`=0, `rs1`=0, `rs2`=0, `rd_in`=0.
  - `busy`=0, `done`=0.
  - `result_a`=0, `result_b`=0, `checksum`=0, `instr_count`=0.
  - State = IDLE, `pc`=0.
- Reset mid-run aborts with no `done` pulse; `op_code` returns to 0 in the same cycle.
- `start` sampled at edge N: `busy`=1 from N+1 (FETCH), and ISSUE occurs at N+2.
- Each instruction takes 3+RD_LATENCY cycles (FETCH, ISSUE, WAIT×L, CAPTURE).
- A full program of P instructions with no halt: `done` asserts 1+P·(3+RD_LATENCY) cycles after `start`.
- Halt at `pc`=0: `done` asserts 2 cycles after `start`.
- Outputs are registered; `op_code`≠0 never persists longer than one cycle.

## Test plan
- Write/read: the program writes reg 4 = 0xE01A (op 0000001, rs1=4), then reads reg 4 (op 0000010, rs1=4, rs2=0), then halts. Expect:
  - `rd_in`=0xFFFF_FFFF_FFFF_E01A on the first issue.
  - `result_a`=0xFFFF_FFFF_FFFF_E01A, `instr_count`=2, single `done` pulse.
- Halt at address 0: `start` -> `done` 2 cycles later, `instr_count`=0, `op_code` stays 0 throughout.
- Full program, no halt: 16 reads with a bench model returning `rs1_out`=1 and `rs2_out`=2. Expect:
  - `checksum`=48, `instr_count`=16.
  - `done` at start+65 cycles for RD_LATENCY=1.
  - No 17th issue.
- Checksum wrap: two captures with `rs1_out`=0xFFFF_FFFF_FFFF_FFFF and `rs2_out`=1 -> `checksum`=0.
- Busy protection: `prog_we` to address 1 and a second `start` mid-run -> both ignored; the program word is unchanged after the run.
- Reset mid-run: assert `reset` during WAIT. Expect immediate `op_code`=0, `busy`=0, `checksum`=0, no `done`. Program contents are retained, and a rerun gives the same results.
